// File: rtl/booth_product_acc.sv
// -----------------------------------------------------------------------------
// booth_product_acc
//
// Accumulates a stream of signed products coming out of a Booth multiplier
// into one wide signed sum. A sum is a run of accepted beats terminated by
// a beat with in_last set. The finished sum is held on the output side until
// the consumer takes it. While it is held, no new beat is accepted.
//
// Parameters
//   SIZE   operand width of the upstream multiplier (product is 2*SIZE bits)
//   GUARD  extra accumulator bits above the product width
//   ACCW   accumulator width, 2*SIZE+GUARD (derived, do not override)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset; drops any partial sum
//   in_valid   product beat present
//   in_ready   block accepts a beat (high in IDLE and ACC)
//   in_p       signed two's-complement product, 2*SIZE bits
//   in_last    final beat of the current sum
//   out_valid  finished sum available (high exactly in HOLD)
//   out_ready  consumer takes the sum
//   out_acc    signed accumulated sum, ACCW bits
//   out_mag    unsigned magnitude of out_acc, ACCW bits
//   out_count  number of beats in the sum, saturating at 65535
//   out_ovf    sticky signed-overflow flag for the current sum
//
// Build option
//   BOOTH_ACC_SAT_EN  when defined, an overflowing addition clamps the sum to
//                     the most positive / most negative ACCW-bit value.
//                     When undefined, the sum wraps in two's complement.
//                     out_ovf is set on overflow in both builds.
//
// Every output is decoded from registered state only. There is no
// combinational path from any in_* input to any out_* output.
// -----------------------------------------------------------------------------
module booth_product_acc #(
  parameter  int SIZE  = 32,
  parameter  int GUARD = 8,
  localparam int ACCW  = 2 * SIZE + GUARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] in_p,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_acc,
  output logic [ACCW-1:0]   out_mag,
  output logic [15:0]       out_count,
  output logic              out_ovf
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;  // waiting for the first beat of a sum
  localparam logic [1:0] S_ACC  = 2'd1;  // summing beats until in_last
  localparam logic [1:0] S_HOLD = 2'd2;  // presenting the result

  localparam logic [ACCW-1:0] ACC_MAX   = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN   = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic [15:0]     COUNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Registered state and next-state values
  // ---------------------------------------------------------------------------
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_nxt;
  logic [15:0]     count;
  logic [15:0]     count_nxt;
  logic            ovf;
  logic            ovf_nxt;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic            accept;
  logic [ACCW-1:0] p_ext;
  logic [ACCW-1:0] sum;
  logic            add_ovf;
  logic [ACCW-1:0] add_res;
  logic [15:0]     count_inc;

  assign in_ready = (state != S_HOLD);
  assign accept   = in_valid && in_ready;

  // Sign-extend the product to the accumulator width.
  // This also holds when GUARD is zero.
  assign p_ext = ACCW'($signed(in_p));

  assign sum = acc + p_ext;

  // Signed overflow: the two operands share a sign and the result does not.
  assign add_ovf = (acc[ACCW-1] == p_ext[ACCW-1]) &&
                   (sum[ACCW-1] != acc[ACCW-1]);

`ifdef BOOTH_ACC_SAT_EN
  // On overflow both operands carry the sign of acc. That sign gives the
  // direction of the clamp.
  assign add_res = add_ovf ? (acc[ACCW-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign add_res = sum;
`endif

  assign count_inc = (count == COUNT_MAX) ? count : count + 16'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;

    case (state)
      S_IDLE: begin
        if (accept) begin
          acc_nxt   = p_ext;
          count_nxt = 16'd1;
          ovf_nxt   = 1'b0;
          state_nxt = in_last ? S_HOLD : S_ACC;
        end
      end

      S_ACC: begin
        if (accept) begin
          acc_nxt   = add_res;
          count_nxt = count_inc;
          ovf_nxt   = ovf | add_ovf;
          state_nxt = in_last ? S_HOLD : S_ACC;
        end
      end

      S_HOLD: begin
        // The result stays frozen until the consumer takes it. The transfer
        // cycle itself never accepts a beat, because in_ready is low here.
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator datapath is reset as well as the control state.
      // The outputs read acc and count directly, so they must show zero
      // after reset rather than whatever partial sum was in progress.
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign out_valid = (state == S_HOLD);
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  // Two's-complement negate for negative sums. The most negative value maps
  // to 2^(ACCW-1), which fits because out_mag is read as unsigned.
  assign out_mag = acc[ACCW-1] ? (~acc + ACCW'(1)) : acc;

endmodule

// File: tb/tb_booth_product_acc.sv
// -----------------------------------------------------------------------------
// tb_booth_product_acc
//
// Bench for booth_product_acc. It drives two instances:
//   u_big    default parameters (SIZE=32, GUARD=8, 72-bit accumulator)
//   u_small  SIZE=4, GUARD=0 (8-bit accumulator), used for overflow and
//            clamp cases that are practical to reach at that width
//
// Expected results go into a queue when the closing beat is driven. They are
// popped and compared when the result is presented. The expected values for
// u_big come from a reference model that detects overflow with one extra
// sum bit.
// -----------------------------------------------------------------------------
module tb_booth_product_acc;

  localparam int BW = 72;
  localparam int SW = 8;

  typedef struct packed {
    logic [BW-1:0] acc;
    logic [BW-1:0] mag;
    logic [15:0]   cnt;
    logic          ovf;
  } bexp_t;

  typedef struct packed {
    logic [SW-1:0] acc;
    logic [SW-1:0] mag;
    logic [15:0]   cnt;
    logic          ovf;
  } sexp_t;

  logic clk;
  logic rst_n;

  // u_big signals
  logic          b_in_valid;
  logic          b_in_ready;
  logic [63:0]   b_in_p;
  logic          b_in_last;
  logic          b_out_valid;
  logic          b_out_ready;
  logic [BW-1:0] b_out_acc;
  logic [BW-1:0] b_out_mag;
  logic [15:0]   b_out_count;
  logic          b_out_ovf;

  // u_small signals
  logic          s_in_valid;
  logic          s_in_ready;
  logic [7:0]    s_in_p;
  logic          s_in_last;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [SW-1:0] s_out_acc;
  logic [SW-1:0] s_out_mag;
  logic [15:0]   s_out_count;
  logic          s_out_ovf;

  int total = 0;
  int bad   = 0;

  bexp_t bq[$];
  sexp_t sq[$];

  // Reference model state for u_big
  logic signed [BW-1:0] m_acc;
  logic [15:0]          m_cnt;
  logic                 m_ovf;
  bit                   m_idle;

  booth_product_acc u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_p      (b_in_p),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_acc   (b_out_acc),
    .out_mag   (b_out_mag),
    .out_count (b_out_count),
    .out_ovf   (b_out_ovf)
  );

  booth_product_acc #(.SIZE(4), .GUARD(0)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_p      (s_in_p),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_acc   (s_out_acc),
    .out_mag   (s_out_mag),
    .out_count (s_out_count),
    .out_ovf   (s_out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model step for one accepted u_big beat.
  task automatic b_model(input logic [63:0] p, input logic last);
    logic signed [BW-1:0] pe;
    logic signed [BW:0]   w;
    bexp_t                e;
    pe = {{8{p[63]}}, p};
    if (m_idle) begin
      m_acc = pe;
      m_cnt = 16'd1;
      m_ovf = 1'b0;
    end else begin
      w = {m_acc[BW-1], m_acc} + {pe[BW-1], pe};
      if (w[BW] != w[BW-1]) begin
        m_ovf = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
        m_acc = w[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
`else
        m_acc = w[BW-1:0];
`endif
      end else begin
        m_acc = w[BW-1:0];
      end
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end
    m_idle = last;
    if (last) begin
      e.acc = m_acc;
      e.mag = m_acc[BW-1] ? BW'(-m_acc) : m_acc;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      bq.push_back(e);
    end
  endtask

  // Drive one beat to u_big and see it accepted on the next rising edge.
  task automatic b_beat(input logic [63:0] p, input logic last);
    @(negedge clk);
    chk("b_in_ready", BW'(b_in_ready), BW'(1));
    b_in_valid = 1'b1;
    b_in_p     = p;
    b_in_last  = last;
    @(posedge clk);
    b_model(p, last);
    #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Call right after the closing beat. Checks latency 1, the result, a
  // hold period with garbage beats offered, and the return to IDLE.
  task automatic b_drain(input int hold_cycles);
    bexp_t e;
    @(negedge clk);
    chk("b_latency_valid", BW'(b_out_valid), BW'(1));
    chk("b_sb_nonempty", BW'(bq.size() != 0), BW'(1));
    e = (bq.size() != 0) ? bq.pop_front() : '0;
    chk("b_acc",   b_out_acc,          e.acc);
    chk("b_mag",   b_out_mag,          e.mag);
    chk("b_count", BW'(b_out_count),   BW'(e.cnt));
    chk("b_ovf",   BW'(b_out_ovf),     BW'(e.ovf));
    for (int i = 0; i < hold_cycles; i++) begin
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_p      = {$urandom, $urandom};
      b_in_last   = 1'(i & 1);
      @(negedge clk);
      chk("b_hold_in_ready", BW'(b_in_ready),  BW'(0));
      chk("b_hold_valid",    BW'(b_out_valid), BW'(1));
      chk("b_hold_acc",      b_out_acc,        e.acc);
      chk("b_hold_count",    BW'(b_out_count), BW'(e.cnt));
    end
    // Transfer cycle: a beat is still offered and must not be taken.
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("b_xfer_valid_low", BW'(b_out_valid), BW'(0));
    chk("b_xfer_ready_hi",  BW'(b_in_ready),  BW'(1));
    b_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_last   = 1'b0;
  endtask

  task automatic s_beat(input logic [7:0] p, input logic last);
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_p     = p;
    s_in_last  = last;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
  endtask

  task automatic s_drain();
    sexp_t e;
    @(negedge clk);
    chk("s_latency_valid", BW'(s_out_valid), BW'(1));
    chk("s_sb_nonempty", BW'(sq.size() != 0), BW'(1));
    e = (sq.size() != 0) ? sq.pop_front() : '0;
    chk("s_acc",   BW'(s_out_acc),   BW'(e.acc));
    chk("s_mag",   BW'(s_out_mag),   BW'(e.mag));
    chk("s_count", BW'(s_out_count), BW'(e.cnt));
    chk("s_ovf",   BW'(s_out_ovf),   BW'(e.ovf));
    s_out_ready = 1'b1;
    @(negedge clk);
    chk("s_xfer_valid_low", BW'(s_out_valid), BW'(0));
    s_out_ready = 1'b0;
  endtask

  initial begin
    sexp_t se;
    rst_n       = 1'b0;
    b_in_valid  = 1'b0;
    b_in_p      = '0;
    b_in_last   = 1'b0;
    b_out_ready = 1'b0;
    s_in_valid  = 1'b0;
    s_in_p      = '0;
    s_in_last   = 1'b0;
    s_out_ready = 1'b0;
    m_acc       = '0;
    m_cnt       = '0;
    m_ovf       = 1'b0;
    m_idle      = 1'b1;

    // Reset state
    #12;
    chk("rst_b_valid", BW'(b_out_valid), BW'(0));
    chk("rst_b_ready", BW'(b_in_ready),  BW'(1));
    chk("rst_b_acc",   b_out_acc,        BW'(0));
    chk("rst_b_count", BW'(b_out_count), BW'(0));
    chk("rst_b_ovf",   BW'(b_out_ovf),   BW'(0));
    chk("rst_s_valid", BW'(s_out_valid), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed-sign sum: -21, 21, -49
    b_beat(-64'sd21, 1'b0);
    b_beat(64'sd21,  1'b0);
    b_beat(-64'sd49, 1'b1);
    b_drain(0);

    // Largest 24x24 product as a single beat. The result is then held
    // for 5 cycles while beats are offered.
    b_beat(64'd16777215 * 64'd16777215, 1'b1);
    chk("b_req33_model", BW'(m_acc), BW'(72'd281474943156225));
    b_drain(5);

    // First sum after the hold must start from a fresh load.
    b_beat(64'sd1000, 1'b0);
    b_beat(-64'sd3,   1'b1);
    b_drain(1);

    // Positive overflow of the 72-bit accumulator
    for (int i = 0; i < 257; i++) b_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    b_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    b_drain(0);

    // Negative sum reaching exactly -2^71, then one more beat overflows it
    for (int i = 0; i < 256; i++) b_beat(64'h8000_0000_0000_0000, 1'b0);
    b_beat(-64'sd1, 1'b1);
    b_drain(0);

    // Reset mid-sum after two of four beats
    b_beat(64'sd100, 1'b0);
    b_beat(64'sd200, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", BW'(b_out_valid), BW'(0));
    chk("rst_mid_ready", BW'(b_in_ready),  BW'(1));
    chk("rst_mid_acc",   b_out_acc,        BW'(0));
    chk("rst_mid_count", BW'(b_out_count), BW'(0));
    m_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    b_beat(64'sd3, 1'b0);
    b_beat(64'sd7, 1'b1);
    chk("rst_mid_model", BW'(m_acc), BW'(10));
    b_drain(0);

    // Reset while a result is held must drop out_valid at once.
    b_beat(64'sd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", BW'(b_out_valid), BW'(0));
    void'(bq.pop_back());
    m_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Small instance: 127 + 1 overflows 8 bits
    s_beat(8'sd127, 1'b0);
    s_beat(8'sd1,   1'b1);
`ifdef BOOTH_ACC_SAT_EN
    se.acc = 8'h7F;
    se.mag = 8'h7F;
`else
    se.acc = 8'h80;
    se.mag = 8'h80;
`endif
    se.cnt = 16'd2;
    se.ovf = 1'b1;
    sq.push_back(se);
    s_drain();

    // Small instance: most negative value alone
    s_beat(8'h80, 1'b1);
    se.acc = 8'h80;
    se.mag = 8'h80;
    se.cnt = 16'd1;
    se.ovf = 1'b0;
    sq.push_back(se);
    s_drain();

    // Count saturation: 65536 back-to-back zero beats
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_p     = 8'd0;
    s_in_last  = 1'b0;
    repeat (65535) @(negedge clk);
    s_in_last = 1'b1;
    se.acc = 8'h00;
    se.mag = 8'h00;
    se.cnt = 16'hFFFF;
    se.ovf = 1'b0;
    sq.push_back(se);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    s_drain();

    chk("b_sb_drained", BW'(bq.size()), BW'(0));
    chk("s_sb_drained", BW'(sq.size()), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_product_acc.md
BOOTH_PRODUCT_ACC -- requirements
Module: booth_product_acc

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand width of the upstream Booth multiplier; product width is 2*SIZE.
REQ-002 SHALL have parameter GUARD, default 8, number of accumulator guard bits; ACCW = 2*SIZE+GUARD.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, product beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat.
REQ-007 SHALL have port in_p, input, 2*SIZE, signed two's-complement product from the Booth multiplier.
REQ-008 SHALL have port in_last, input, 1, marks the final beat of a sum.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port out_acc, output, ACCW, signed accumulated sum.
REQ-012 SHALL have port out_mag, output, ACCW, unsigned magnitude of out_acc.
REQ-013 SHALL have port out_count, output, 16, number of beats in the sum.
REQ-014 SHALL have port out_ovf, output, 1, sticky overflow flag for the current sum.

Function
REQ-015 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-016 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-017 SHALL treat a beat as accepted only when in_valid&&in_ready at a rising clk edge; in_p and in_last SHALL be ignored otherwise.
REQ-018 IDLE accept SHALL load acc=sign-extended in_p, count=1, ovf=0; the next state SHALL be HOLD if in_last, else ACC.
REQ-019 ACC accept SHALL set acc=acc+sign-extended in_p and count=count+1; the next state SHALL be HOLD if in_last, else ACC.
REQ-020 count SHALL saturate at 65535, with no wrap.
REQ-021 out_valid SHALL be 1 exactly when in HOLD, first asserted the cycle after the in_last beat is accepted (latency 1).
REQ-022 out_acc, out_mag, out_count and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 HOLD with out_ready=1 SHALL return to IDLE; out_valid SHALL be 0 the following cycle.
REQ-024 No new beat SHALL be accepted in the transfer cycle; the earliest next accept SHALL occur in the first IDLE cycle.
REQ-025 ovf SHALL be set when a signed ACCW-bit addition overflows (same operand signs, result sign differs) and SHALL remain set until the next IDLE load.
REQ-026 out_mag SHALL equal acc when acc>=0, else (~acc)+1 as unsigned ACCW, so the most negative value yields 2^(ACCW-1).
REQ-027 Outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from in_* to out_*.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=1 (asynchronous, including mid-sum), discarding any partial sum.
REQ-029 After rst_n deasserts, the first accept SHALL behave as an IDLE load.

Configuration
REQ-030 With macro BOOTH_ACC_SAT_EN defined, an overflowing addition SHALL clamp acc to 2^(ACCW-1)-1 (positive overflow) or -2^(ACCW-1) (negative overflow), and ovf SHALL be set.
REQ-031 Without BOOTH_ACC_SAT_EN, acc SHALL wrap in two's complement and ovf SHALL still be set; all other behaviour is identical.

Verification
REQ-032 Beats -21, 21, -49 (last) -> out_acc=-49, out_mag=49, out_count=3, out_ovf=0, out_valid high one cycle after the third accept.
REQ-033 A single beat 16777215*16777215 with in_last, accepted in IDLE -> out_acc=281474943156225, out_count=1, out_valid on the next cycle.
REQ-034 out_ready held low for 5 HOLD cycles while in_valid=1 -> in_ready=0, outputs unchanged, no beat counted; out_ready=1 -> IDLE next cycle.
REQ-035 SIZE=4, GUARD=0, beats 127 then 1 (last) -> with BOOTH_ACC_SAT_EN: out_acc=127, out_ovf=1; without it: out_acc=-128, out_ovf=1.
REQ-036 rst_n pulsed low after two of four beats -> immediate IDLE with out_valid=0; new beats 3, 7 (last) -> out_acc=10, out_count=2.
REQ-037 Beat -128 alone with SIZE=4, GUARD=0 -> out_acc=-128, out_mag=128.
